// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- instruction prefetcher feeding a decoder.
//
// Reads program memory one word per cycle into a DEPTH-entry FIFO. Reads are
// only issued when a FIFO slot is guaranteed for the return. A flush redirects
// the fetch address and drops everything queued or in flight.
//
// Optional feature: define FETCH_STALL_CNT_EN to build the decoder-starvation
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
//
// Parameters:
//   DEPTH   prefetch FIFO entries (2, 4 or 8)
//   ADDR_W  program counter / memory address width
// Ports:
//   clk, rstn            clock, async active-low reset
//   fetch_en             allow new reads
//   flush, flush_addr    redirect request and its target address
//   mem_re, mem_addr     program memory read strobe/address
//   mem_data             read data, valid the cycle after mem_re
//   instr_valid/_ready   decoder handshake
//   instr_data, instr_pc head-of-FIFO word and the address it came from
//   stall_cnt            cycles the decoder waited while fetching was active
module instr_fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [15:0]       data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              inflight_q;
  logic [ADDR_W-1:0] pc, rd_addr_q;
  logic [OW-1:0]     occ;
  logic [1:0]        state;
  logic              credit, wr_en, pop;

  // Occupancy includes the slot reserved by the read whose data arrives now.
  assign occ    = OW'(count) + OW'(inflight_q);
  assign credit = occ < OW'(DEPTH);

  // State is decoded from the registered occupancy so the first read goes out
  // in the very first cycle fetch_en is seen; reset forces IDLE.
  always_comb begin
    state = S_IDLE;
    if (rstn && fetch_en) state = credit ? S_FETCH : S_FULL;
  end

  assign mem_re      = (state == S_FETCH) && !flush;
  assign mem_addr    = pc;
  // A flush in the return cycle voids the arriving word.
  assign wr_en       = inflight_q && !flush;
  assign instr_valid = (count != '0) && !flush;
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = fifo_q[rd_ptr].data;
  assign instr_pc    = fifo_q[rd_ptr].pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc         <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (flush) begin
      pc         <= flush_addr;
      inflight_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      inflight_q <= mem_re;
      if (mem_re) begin
        pc        <= pc + 1'b1;
        rd_addr_q <= pc;
      end
      if (wr_en) begin
        fifo_q[wr_ptr] <= '{data: mem_data, pc: rd_addr_q};
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if ((state != S_IDLE) && instr_ready && !instr_valid && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=4, ADDR_W=5). Program memory is
// modelled as mem_data = 16'h0A00 + address, returned one cycle after mem_re.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          fetch_en = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_addr = '0;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data = 16'h0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [15:0]   instr_data;
  logic [AW-1:0] instr_pc;
  logic [15:0]   stall_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .fetch_en(fetch_en), .flush(flush),
    .flush_addr(flush_addr), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_data(mem_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Program memory: one-cycle read latency.
  always @(posedge clk)
    mem_data <= mem_re ? (16'h0A00 + 16'(mem_addr)) : 16'hBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    rstn = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; flush = 1'b0; flush_addr = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  typedef struct {
    bit          rs;    // reset before applying this vector
    bit          fe, rd, fl;
    logic [4:0]  fa;
    bit          e_re;
    logic [4:0]  e_ad;
    bit          e_v;
    logic [4:0]  e_pc;
  } vec_t;

  vec_t vt[$];

`ifdef FETCH_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd2;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  initial begin
    int nre;
    logic last_re;
    logic [AW-1:0] exp_addr, exp_pc;
    int ndel;

    // rs fe rd fl fa   re ad  v pc
    // streaming from reset
    vt.push_back('{1,1,1,0,0,  1,0, 0,0});
    vt.push_back('{0,1,1,0,0,  1,1, 0,0});
    vt.push_back('{0,1,1,0,0,  1,2, 1,0});
    vt.push_back('{0,1,1,0,0,  1,3, 1,1});
    vt.push_back('{0,1,1,0,0,  1,4, 1,2});
    // flush with 3 queued words plus one in flight, ready high in flush cycle
    vt.push_back('{1,1,0,0,0,  1,0, 0,0});
    vt.push_back('{0,1,0,0,0,  1,1, 0,0});
    vt.push_back('{0,1,0,0,0,  1,2, 1,0});
    vt.push_back('{0,1,0,0,0,  1,3, 1,0});
    vt.push_back('{0,1,1,1,20, 0,0, 0,0});
    vt.push_back('{0,1,1,0,0,  1,20,0,0});
    vt.push_back('{0,1,1,0,0,  1,21,0,0});
    vt.push_back('{0,1,1,0,0,  1,22,1,20});
    vt.push_back('{0,1,1,0,0,  1,23,1,21});
    // back-to-back flushes: last address wins
    vt.push_back('{0,1,1,1,10, 0,0, 0,0});
    vt.push_back('{0,1,1,1,12, 0,0, 0,0});
    vt.push_back('{0,1,1,0,0,  1,12,0,0});
    vt.push_back('{0,1,1,0,0,  1,13,0,0});
    vt.push_back('{0,1,1,0,0,  1,14,1,12});
    // fetch_en drops with a read in flight: word still lands, pc holds
    vt.push_back('{1,1,0,0,0,  1,0, 0,0});
    vt.push_back('{0,0,0,0,0,  0,0, 0,0});
    vt.push_back('{0,0,0,0,0,  0,0, 1,0});
    vt.push_back('{0,1,0,0,0,  1,1, 1,0});
    vt.push_back('{0,1,1,0,0,  1,2, 1,0});
    vt.push_back('{0,1,1,0,0,  1,3, 1,1});

    // reset state
    #1;
    chk("rst mem_re", mem_re, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst instr_valid", instr_valid, 0);
    chk("rst instr_data", instr_data, 0);
    chk("rst instr_pc", instr_pc, 0);
    chk("rst stall_cnt", stall_cnt, 0);

    foreach (vt[i]) begin
      if (vt[i].rs) do_reset();
      fetch_en = vt[i].fe; instr_ready = vt[i].rd;
      flush = vt[i].fl; flush_addr = vt[i].fa;
      @(negedge clk);
      chk($sformatf("v%0d mem_re", i), mem_re, vt[i].e_re);
      if (vt[i].e_re) chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].e_ad);
      chk($sformatf("v%0d instr_valid", i), instr_valid, vt[i].e_v);
      if (vt[i].e_v) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, vt[i].e_pc);
        chk($sformatf("v%0d instr_data", i), instr_data, 16'h0A00 + 16'(vt[i].e_pc));
      end
      @(posedge clk); #1;
    end

    // backpressure fills FIFO with exactly DEPTH reads, then drain and wrap
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b0;
    nre = 0; last_re = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_re) nre++;
      last_re = mem_re;
      @(posedge clk); #1;
    end
    chk("full reads", nre, DEPTH);
    chk("full mem_re", last_re, 0);
    instr_ready = 1'b1;
    exp_addr = 5'd4; exp_pc = 5'd0; ndel = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (mem_re) begin
        chk("run mem_addr", mem_addr, exp_addr);
        exp_addr = exp_addr + 1'b1;
      end
      if (instr_valid) begin
        chk("run instr_pc", instr_pc, exp_pc);
        chk("run instr_data", instr_data, 16'h0A00 + 16'(exp_pc));
        exp_pc = exp_pc + 1'b1;
        ndel++;
      end
      @(posedge clk); #1;
    end
    chk("wrap reached", (ndel >= 34), 1);

    // async reset with a full FIFO
    instr_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre-rst valid", instr_valid, 1);
    chk("pre-rst mem_re", mem_re, 0);
    rstn = 1'b0;
    #1;
    chk("mid-rst mem_re", mem_re, 0);
    chk("mid-rst mem_addr", mem_addr, 0);
    chk("mid-rst valid", instr_valid, 0);
    chk("mid-rst data", instr_data, 0);
    chk("mid-rst pc", instr_pc, 0);
    chk("mid-rst stall", stall_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    chk("post-rst mem_re", mem_re, 1);
    chk("post-rst mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-rst c1 valid", instr_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-rst valid", instr_valid, 1);
    chk("post-rst pc", instr_pc, 0);
    chk("stall_cnt", stall_cnt, STALL_EXP);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: DEPTH, 4, prefetch FIFO entries; legal values 2, 4 or 8.
REQ-002 Parameter: ADDR_W, 5, program-counter and program-memory address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 fetch_en  input  1  1 = fetching allowed; 0 = no new reads issued.
REQ-006 flush  input  1  redirect request; sampled each cycle.
REQ-007 flush_addr  input  ADDR_W  new fetch address, valid while flush=1.
REQ-008 mem_re  output  1  program-memory read strobe.
REQ-009 mem_addr  output  ADDR_W  program-memory read address.
REQ-010 mem_data  input  16  read data, valid exactly one cycle after mem_re=1.
REQ-011 instr_valid  output  1  instr_data/instr_pc hold a valid instruction.
REQ-012 instr_ready  input  1  decoder accepts; transfer when instr_valid & instr_ready.
REQ-013 instr_data  output  16  instruction word at FIFO head.
REQ-014 instr_pc  output  ADDR_W  address the head word was fetched from.
REQ-015 stall_cnt  output  16  decoder-starvation counter (see Configuration).

Function
REQ-016 States: IDLE (fetch_en=0), FETCH (reads issued), FULL (no credit); mem_re=1 only in FETCH.
REQ-017 IDLE->FETCH when fetch_en=1 and credit>0; FETCH->FULL when credit=0; FULL->FETCH when credit>0; any state->IDLE when fetch_en=0.
REQ-018 Credit = DEPTH - fifo_count - inflight, where inflight = 1 if mem_re was 1 last cycle and not voided by flush; a read is never issued without a free slot for its return.
REQ-019 On mem_re=1, mem_addr=pc; pc increments by 1 the same edge, wrapping 2^ADDR_W-1 -> 0.
REQ-020 Returned mem_data and its address are written into the FIFO at the edge ending the cycle it is valid; instr_valid rises the following cycle (first instruction: mem_re at cycle N, instr_valid at cycle N+2).
REQ-021 FIFO is first-in-first-out; simultaneous write and pop in the same cycle keep fifo_count unchanged; pop on empty and write on full never occur.
REQ-022 instr_valid = FIFO not empty AND flush=0; instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-023 flush=1: FIFO emptied, in-flight return discarded (mem_data next cycle ignored), pc loaded with flush_addr, mem_re=0 that cycle; first read of flush_addr issued the next cycle if fetch_en=1.
REQ-024 flush with instr_ready=1 in the same cycle: no transfer occurs; flush has priority.
REQ-025 fetch_en falling with a read in flight: that return is still written to the FIFO; pc holds.
REQ-026 Repeated flush on consecutive cycles: last flush_addr wins, no reads issued until flush=0.

Reset
REQ-027 rstn=0 asynchronously: state=IDLE, pc=0, FIFO empty, inflight=0, mem_re=0, mem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, stall_cnt=0.
REQ-028 Reset asserted mid-operation discards all FIFO contents and the in-flight read; after release fetching restarts from address 0.

Configuration
REQ-029 Macro FETCH_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle with instr_ready=1, instr_valid=0 and state!=IDLE; saturates at 16'hFFFF; cleared only by reset.
REQ-030 FETCH_STALL_CNT_EN undefined: counter logic not compiled in; stall_cnt tied to 0.

Verification
REQ-031 Reset release, fetch_en=1, instr_ready=1, mem_data=16'h0A00+addr -> mem_re at cycle 0 addr 0; instr_valid at cycle 2 with instr_data=16'h0A00, instr_pc=0; thereafter one instruction per cycle, pc order 0,1,2,...
REQ-032 instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 reads issued, state FULL, mem_re=0; instr_ready=1 -> words 0..3 delivered in order, fetching resumes at 4.
REQ-033 Free-running to pc=31 -> next mem_addr=0; instr_pc sequence 30,31,0,1.
REQ-034 flush=1, flush_addr=5'd20 while FIFO holds 3 words and a read is in flight -> instr_valid=0 that cycle, next mem_addr=20, next delivered instr_pc=20, no stale word delivered.
REQ-035 rstn pulsed low mid-run with full FIFO -> all outputs zero immediately; after release first delivered instr_pc=0.
REQ-036 With FETCH_STALL_CNT_EN, fetch_en=1, instr_ready=1 held continuously from reset release -> stall_cnt=2 once instr_valid first rises; without macro stall_cnt stays 0.
